// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling, framing-error detection
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_RX_bit        asynchronous serial line, idle high
//   o_RX_byte       last correctly framed byte, held until the next good byte
//   o_RX_done       one-cycle pulse when o_RX_byte is updated
//   o_frame_err     one-cycle pulse when the stop bit is sampled low
//   o_receive_state high from start-edge detection until return to idle
module uart_rx #(
   parameter int CLOCK_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_RX_bit,
   output logic [7:0] o_RX_byte,
   output logic       o_RX_done,
   output logic       o_frame_err,
   output logic       o_receive_state
);
   localparam int HALF_BIT = CLOCK_PER_BIT / 2;
   localparam logic [10:0] BIT_END  = 11'(CLOCK_PER_BIT - 1);
   localparam logic [10:0] HALF_END = 11'(HALF_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT, CLEANUP} state_t;
   state_t      state_q, state_d;
   logic        meta_q, meta_d, rx_s_q, rx_s_d;
   logic [10:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d, byte_q, byte_d;
   logic        done_q, done_d, err_q, err_d;
   always_comb begin
      meta_d  = i_RX_bit;
      rx_s_d  = meta_q;
      state_d = state_q;
      cnt_d   = cnt_q + 11'd1;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: if (cnt_q == HALF_END) begin
            cnt_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
         end
         DATA: if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            done_d  = rx_s_q;
            err_d   = !rx_s_q;
            byte_d  = rx_s_q ? shift_q : byte_q;
            state_d = rx_s_q ? CLEANUP : BREAK_WAIT;
         end
         // a held-low line must return high before a new start edge can be seen
         BREAK_WAIT: begin
            cnt_d = '0;
            if (rx_s_q) state_d = CLEANUP;
         end
         CLEANUP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         meta_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         meta_q  <= meta_d;
         rx_s_q  <= rx_s_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
   assign o_RX_byte       = byte_q;
   assign o_RX_done       = done_q;
   assign o_frame_err     = err_q;
   assign o_receive_state = (state_q != IDLE);
endmodule
